// File: rtl/dm_chunk_scheduler.sv
// dm_chunk_scheduler
// ------------------
// Sequences data_mover_bram for transfers longer than one BRAM run. A job of
// i_total_cnt words is split into chunks of at most CHUNK words. Each chunk
// gets one o_dm_run pulse with its length on o_dm_num_cnt. The scheduler waits
// for the mover to go idle before a run and for its done pulse after a run.
// A per-chunk watchdog, a level abort and a single completion pulse are provided.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-high reset
//   i_start       start request, accepted only while idle
//   i_total_cnt   total words, sampled with an accepted i_start
//   i_abort       level; stop issuing further chunks
//   i_dm_idle     mover o_idle
//   i_dm_done     mover o_done (1-cycle pulse)
//   o_dm_run      1-cycle run pulse to the mover
//   o_dm_num_cnt  chunk length to the mover
//   o_idle        scheduler idle
//   o_busy        job in progress (WAIT_IDLE / ISSUE / WAIT_DONE)
//   o_done        1-cycle job completion pulse
//   o_err         sticky watchdog timeout flag
//   o_aborted     sticky abort flag
//   o_chunk_idx   chunks completed in the current job
//   o_remaining   words not yet moved
module dm_chunk_scheduler #(
    parameter int CNT_BIT = 31,
    parameter int AWIDTH  = 12,
    parameter int CHUNK   = 3840,
    parameter int TO_BIT  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_start,
    input  logic [CNT_BIT-1:0] i_total_cnt,
    input  logic               i_abort,
    input  logic               i_dm_idle,
    input  logic               i_dm_done,
    output logic               o_dm_run,
    output logic [AWIDTH-1:0]  o_dm_num_cnt,
    output logic               o_idle,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err,
    output logic               o_aborted,
    output logic [CNT_BIT-1:0] o_chunk_idx,
    output logic [CNT_BIT-1:0] o_remaining
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_IDLE,
        ISSUE,
        WAIT_DONE,
        DONE
    } state_t;

    localparam logic [CNT_BIT-1:0] LP_CHUNK = CNT_BIT'(CHUNK);

    state_t             r_state;
    logic [CNT_BIT-1:0] r_remaining;
    logic [CNT_BIT-1:0] r_chunk_idx;
    logic [AWIDTH-1:0]  r_num_cnt;
    logic               r_err;
    logic               r_aborted;
    logic [TO_BIT-1:0]  r_wd;

    state_t             w_state_nx;
    logic [CNT_BIT-1:0] w_remaining_nx;
    logic [CNT_BIT-1:0] w_chunk_idx_nx;
    logic [AWIDTH-1:0]  w_num_cnt_nx;
    logic               w_err_nx;
    logic               w_aborted_nx;
    logic [TO_BIT-1:0]  w_wd_nx;

    logic [CNT_BIT-1:0] w_rem_after;
    logic [TO_BIT-1:0]  w_wd_inc;

    // A chunk never exceeds the remaining count, so this cannot underflow.
    assign w_rem_after = r_remaining - CNT_BIT'(r_num_cnt);
    assign w_wd_inc    = r_wd + TO_BIT'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_chunk_idx <= '0;
            r_num_cnt   <= '0;
            r_err       <= 1'b0;
            r_aborted   <= 1'b0;
            r_wd        <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_remaining <= w_remaining_nx;
            r_chunk_idx <= w_chunk_idx_nx;
            r_num_cnt   <= w_num_cnt_nx;
            r_err       <= w_err_nx;
            r_aborted   <= w_aborted_nx;
            r_wd        <= w_wd_nx;
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_remaining_nx = r_remaining;
        w_chunk_idx_nx = r_chunk_idx;
        w_num_cnt_nx   = r_num_cnt;
        w_err_nx       = r_err;
        w_aborted_nx   = r_aborted;
        w_wd_nx        = r_wd;

        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_remaining_nx = i_total_cnt;
                    w_chunk_idx_nx = '0;
                    w_err_nx       = 1'b0;
                    w_aborted_nx   = 1'b0;
                    w_state_nx     = (i_total_cnt == '0) ? DONE : WAIT_IDLE;
                end
            end

            WAIT_IDLE: begin
                if (i_abort) begin
                    w_aborted_nx = 1'b1;
                    w_state_nx   = DONE;
                end else if (i_dm_idle) begin
                    // CHUNK < 2^AWIDTH, so the truncation is lossless.
                    w_num_cnt_nx = AWIDTH'((r_remaining < LP_CHUNK) ? r_remaining : LP_CHUNK);
                    w_state_nx   = ISSUE;
                end
            end

            ISSUE: begin
                w_wd_nx    = '0;
                w_state_nx = WAIT_DONE;
            end

            WAIT_DONE: begin
                w_wd_nx = w_wd_inc;
                // Done beats a simultaneous timeout; abort only acts once the
                // in-flight chunk has completed.
                if (i_dm_done) begin
                    w_remaining_nx = w_rem_after;
                    w_chunk_idx_nx = r_chunk_idx + CNT_BIT'(1);
                    if (w_rem_after == '0) begin
                        w_state_nx = DONE;
                    end else if (i_abort) begin
                        w_aborted_nx = 1'b1;
                        w_state_nx   = DONE;
                    end else begin
                        w_state_nx = WAIT_IDLE;
                    end
                end else if (w_wd_inc == '1) begin
                    w_err_nx   = 1'b1;
                    w_state_nx = DONE;
                end
            end

            DONE: begin
                w_state_nx = IDLE;
            end

            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    assign o_dm_run     = (r_state == ISSUE);
    assign o_idle       = (r_state == IDLE);
    assign o_busy       = (r_state == WAIT_IDLE) || (r_state == ISSUE) || (r_state == WAIT_DONE);
    assign o_done       = (r_state == DONE);
    assign o_dm_num_cnt = r_num_cnt;
    assign o_err        = r_err;
    assign o_aborted    = r_aborted;
    assign o_chunk_idx  = r_chunk_idx;
    assign o_remaining  = r_remaining;

endmodule

// File: tb/tb_dm_chunk_scheduler.sv
// tb_dm_chunk_scheduler
// ---------------------
// Self-checking bench for dm_chunk_scheduler. A small data-mover model answers
// each run pulse with a done pulse a few cycles later. Expected chunk lengths and
// the remaining count at each run are queued when a job starts and popped as runs
// appear. Table vectors cover whole jobs; hand-written sequences cover timeout,
// back-pressure, start latency and asynchronous reset.
module tb_dm_chunk_scheduler;

    localparam int CNT_BIT = 31;
    localparam int AWIDTH  = 12;
    localparam int CHUNK   = 3840;
    localparam int TO_BIT  = 4;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               iStart = 1'b0;
    logic [CNT_BIT-1:0] iTotal = '0;
    logic               iAbort = 1'b0;
    logic               dmIdle = 1'b0;
    logic               dmDone = 1'b0;

    logic               oDmRun;
    logic [AWIDTH-1:0]  oDmNumCnt;
    logic               oIdle;
    logic               oBusy;
    logic               oDone;
    logic               oErr;
    logic               oAborted;
    logic [CNT_BIT-1:0] oChunkIdx;
    logic [CNT_BIT-1:0] oRemaining;

    dm_chunk_scheduler #(
        .CNT_BIT(CNT_BIT),
        .AWIDTH (AWIDTH),
        .CHUNK  (CHUNK),
        .TO_BIT (TO_BIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_start     (iStart),
        .i_total_cnt (iTotal),
        .i_abort     (iAbort),
        .i_dm_idle   (dmIdle),
        .i_dm_done   (dmDone),
        .o_dm_run    (oDmRun),
        .o_dm_num_cnt(oDmNumCnt),
        .o_idle      (oIdle),
        .o_busy      (oBusy),
        .o_done      (oDone),
        .o_err       (oErr),
        .o_aborted   (oAborted),
        .o_chunk_idx (oChunkIdx),
        .o_remaining (oRemaining)
    );

    always #5 clk = ~clk;

    // Data-mover model, updated on the falling edge so it never races the DUT.
    bit idleEnable   = 1'b1;
    bit moverRespond = 1'b1;
    bit mvBusy       = 1'b0;
    int mvCnt        = 0;

    always @(negedge clk) begin
        dmDone = 1'b0;
        if (oDmRun) begin
            mvBusy = 1'b1;
            mvCnt  = 3;
        end else if (mvBusy && moverRespond) begin
            mvCnt = mvCnt - 1;
            if (mvCnt == 0) begin
                dmDone = 1'b1;
                mvBusy = 1'b0;
            end
        end
        dmIdle = idleEnable && !mvBusy;
    end

    typedef struct {
        logic [AWIDTH-1:0]  cnt;
        logic [CNT_BIT-1:0] rem;
    } run_t;

    typedef struct {
        string name;
        int    total;
        bit    abortFirst;
        int    expIdx;
        int    expRem;
        bit    expAborted;
    } vec_t;

    run_t sbQ[$];
    vec_t vecs[7];

    int nVec  = 0;
    int nMiss = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nMiss++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for o_done with a cycle budget; returns the number of ticks taken.
    task automatic waitDone(input string name, output int cycles);
        cycles = 0;
        while (!oDone && cycles < 500) begin
            tick();
            cycles++;
        end
        checkOutput({name, " done seen"}, 64'(oDone), 64'd1);
    endtask

    task automatic applyStimulus(input vec_t v);
        int   rem;
        int   c;
        int   doneCnt;
        bit   seenRun;
        bit   finished;
        run_t e;
        rem      = v.total;
        doneCnt  = 0;
        seenRun  = 1'b0;
        finished = 1'b0;
        sbQ.delete();
        for (int k = 0; k < v.expIdx; k++) begin
            c = (rem < CHUNK) ? rem : CHUNK;
            e.cnt = AWIDTH'(c);
            e.rem = CNT_BIT'(rem);
            sbQ.push_back(e);
            rem = rem - c;
        end

        iStart = 1'b1;
        iTotal = CNT_BIT'(v.total);
        tick();
        iStart = 1'b0;

        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            if (oDmRun) begin
                seenRun = 1'b1;
                if (sbQ.size() == 0) begin
                    checkOutput({v.name, " unexpected run"}, 64'd1, 64'd0);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput({v.name, " run num_cnt"}, 64'(oDmNumCnt), 64'(e.cnt));
                    checkOutput({v.name, " remaining at run"}, 64'(oRemaining), 64'(e.rem));
                end
            end
            if (v.abortFirst && seenRun && oBusy && !oDmRun) iAbort = 1'b1;
            if (oDone) begin
                doneCnt++;
                finished = 1'b1;
            end else begin
                tick();
            end
        end
        checkOutput({v.name, " finished"}, 64'(finished), 64'd1);
        checkOutput({v.name, " chunk_idx"}, 64'(oChunkIdx), 64'(v.expIdx));
        checkOutput({v.name, " remaining"}, 64'(oRemaining), 64'(v.expRem));
        checkOutput({v.name, " aborted"}, 64'(oAborted), 64'(v.expAborted));
        checkOutput({v.name, " err"}, 64'(oErr), 64'd0);
        checkOutput({v.name, " runs outstanding"}, 64'(sbQ.size()), 64'd0);
        iAbort = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (oDone) doneCnt++;
        end
        checkOutput({v.name, " done pulses"}, 64'(doneCnt), 64'd1);
        checkOutput({v.name, " back to idle"}, 64'(oIdle), 64'd1);
    endtask

    initial begin
        int runAt;
        int doneAt;
        int runs;
        int waited;
        bit seen;
        vec_t v;

        vecs[0] = '{"single", 3840,  1'b0, 1, 0,    1'b0};
        vecs[1] = '{"multi",  10000, 1'b0, 3, 0,    1'b0};
        vecs[2] = '{"zero",   0,     1'b0, 0, 0,    1'b0};
        vecs[3] = '{"one",    1,     1'b0, 1, 0,    1'b0};
        vecs[4] = '{"exact2", 7680,  1'b0, 2, 0,    1'b0};
        vecs[5] = '{"plus1",  3841,  1'b0, 2, 0,    1'b0};
        vecs[6] = '{"abort",  10000, 1'b1, 1, 6160, 1'b1};

        // Reset state.
        tick();
        tick();
        checkOutput("reset idle", 64'(oIdle), 64'd1);
        checkOutput("reset busy", 64'(oBusy), 64'd0);
        checkOutput("reset run", 64'(oDmRun), 64'd0);
        checkOutput("reset done", 64'(oDone), 64'd0);
        checkOutput("reset err", 64'(oErr), 64'd0);
        checkOutput("reset aborted", 64'(oAborted), 64'd0);
        checkOutput("reset remaining", 64'(oRemaining), 64'd0);
        checkOutput("reset chunk_idx", 64'(oChunkIdx), 64'd0);
        checkOutput("reset num_cnt", 64'(oDmNumCnt), 64'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

        // Start latency with the mover already idle: run two samples after start.
        iStart = 1'b1;
        iTotal = CNT_BIT'(50);
        tick();
        iStart = 1'b0;
        checkOutput("latency busy", 64'(oBusy), 64'd1);
        checkOutput("latency no early run", 64'(oDmRun), 64'd0);
        tick();
        checkOutput("latency run", 64'(oDmRun), 64'd1);
        checkOutput("latency num_cnt", 64'(oDmNumCnt), 64'd50);
        waitDone("latency", waited);
        tick();

        // Watchdog timeout: mover never answers.
        moverRespond = 1'b0;
        iStart = 1'b1;
        iTotal = CNT_BIT'(5000);
        tick();
        iStart = 1'b0;
        runAt = -1;
        for (int cyc = 0; cyc < 10 && runAt < 0; cyc++) begin
            if (oDmRun) runAt = cyc;
            else tick();
        end
        checkOutput("timeout run seen", 64'(runAt >= 0), 64'd1);
        doneAt = 0;
        while (!oDone && doneAt < 100) begin
            tick();
            doneAt++;
        end
        checkOutput("timeout latency", 64'(doneAt), 64'd16);
        checkOutput("timeout err", 64'(oErr), 64'd1);
        checkOutput("timeout remaining", 64'(oRemaining), 64'd5000);
        checkOutput("timeout chunk_idx", 64'(oChunkIdx), 64'd0);
        checkOutput("timeout aborted", 64'(oAborted), 64'd0);
        tick();
        moverRespond = 1'b1;
        mvBusy = 1'b0;
        tick();
        tick();
        v = '{"clear err", 100, 1'b0, 1, 0, 1'b0};
        applyStimulus(v);

        // Back-pressure: mover reports busy for 20 cycles.
        idleEnable = 1'b0;
        tick();
        iStart = 1'b1;
        iTotal = CNT_BIT'(100);
        tick();
        iStart = 1'b0;
        runs = 0;
        for (int k = 0; k < 20; k++) begin
            if (oDmRun) runs++;
            tick();
        end
        checkOutput("backpressure no run", 64'(runs), 64'd0);
        checkOutput("backpressure busy", 64'(oBusy), 64'd1);
        idleEnable = 1'b1;
        tick();
        checkOutput("backpressure run", 64'(oDmRun), 64'd1);
        checkOutput("backpressure num_cnt", 64'(oDmNumCnt), 64'd100);
        waitDone("backpressure", waited);
        checkOutput("backpressure remaining", 64'(oRemaining), 64'd0);
        checkOutput("backpressure chunk_idx", 64'(oChunkIdx), 64'd1);
        tick();

        // Asynchronous reset in the middle of WAIT_DONE.
        iStart = 1'b1;
        iTotal = CNT_BIT'(10000);
        tick();
        iStart = 1'b0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
            if (oDmRun) seen = 1'b1;
            else tick();
        end
        checkOutput("reset-mid run seen", 64'(seen), 64'd1);
        tick();
        tick();
        checkOutput("reset-mid busy before", 64'(oBusy), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("reset-mid idle", 64'(oIdle), 64'd1);
        checkOutput("reset-mid busy", 64'(oBusy), 64'd0);
        checkOutput("reset-mid run", 64'(oDmRun), 64'd0);
        checkOutput("reset-mid remaining", 64'(oRemaining), 64'd0);
        tick();
        reset = 1'b0;
        mvBusy = 1'b0;
        tick();
        tick();
        v = '{"after reset", 10000, 1'b0, 3, 0, 1'b0};
        applyStimulus(v);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule

// File: doc/dm_chunk_scheduler.md
Name: dm_chunk_scheduler

Overview:
Controller that sequences data_mover_bram for transfers longer than one BRAM run. Accepts a total word count, splits it into chunks of at most CHUNK words, issues one i_run per chunk with the matching i_num_cnt, and waits on the mover's o_done/o_idle between chunks. Provides a per-chunk watchdog, abort, and a single completion pulse to the host/control-register layer.

Parameters:
CNT_BIT, 31, width of total-count and remaining-count registers
AWIDTH, 12, width of the per-chunk count driven to the data mover (i_num_cnt)
CHUNK, 3840, maximum words per run; must be 1..2^AWIDTH-1
TO_BIT, 16, watchdog counter width; timeout after 2^TO_BIT-1 cycles in WAIT_DONE

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
i_start  in  1  start request; accepted only in IDLE
i_total_cnt  in  CNT_BIT  total words; sampled on the accepted i_start
i_abort  in  1  level; stop issuing further chunks
i_dm_idle  in  1  data mover o_idle
i_dm_done  in  1  data mover o_done (1-cycle pulse)
o_dm_run  out  1  1-cycle run pulse to the data mover
o_dm_num_cnt  out  AWIDTH  chunk length to the data mover
o_idle  out  1  high in IDLE
o_busy  out  1  high in WAIT_IDLE, ISSUE, WAIT_DONE
o_done  out  1  1-cycle completion pulse
o_err  out  1  sticky timeout flag; cleared on the next accepted i_start
o_aborted  out  1  sticky abort flag; cleared on the next accepted i_start
o_chunk_idx  out  CNT_BIT  number of chunks completed in the current job
o_remaining  out  CNT_BIT  words not yet moved

Behaviour:
- Reset (async, active-high) forces state IDLE. All outputs are 0 except o_idle=1. Counters are cleared.
- States: IDLE, WAIT_IDLE, ISSUE, WAIT_DONE, DONE. All outputs are registered or decoded from the registered state; there is no combinational input-to-output path.
- IDLE:
  - i_start=1 latches o_remaining=i_total_cnt and clears o_chunk_idx, o_err, o_aborted.
  - If i_total_cnt==0, go to DONE; otherwise go to WAIT_IDLE.
  - i_start in any other state is ignored.
- WAIT_IDLE:
  - If i_abort=1, set o_aborted and go to DONE. Abort takes priority over i_dm_idle in the same cycle.
  - Else, if i_dm_idle=1, load o_dm_num_cnt = min(o_remaining, CHUNK), truncated to AWIDTH, and go to ISSUE.
- ISSUE:
  - o_dm_run=1 for exactly this one cycle.
  - Clear the watchdog and go to WAIT_DONE unconditionally.
- WAIT_DONE:
  - Watchdog increments every cycle.
  - On i_dm_done: o_remaining -= o_dm_num_cnt and o_chunk_idx += 1.
    - If the new remaining is 0 or i_abort=1, go to DONE; o_aborted is set only if words remain.
    - Otherwise go to WAIT_IDLE.
  - i_abort alone does not leave WAIT_DONE; the in-flight chunk always completes.
  - Watchdog reaching all-ones without i_dm_done sets o_err and goes to DONE; remaining is left unchanged.
  - i_dm_done and timeout in the same cycle: done wins and o_err is not set.
- DONE: o_done=1 for one cycle, then go to IDLE. o_dm_num_cnt, o_chunk_idx, o_remaining and the sticky flags hold until the next start.
- o_dm_num_cnt is stable from ISSUE through the end of WAIT_DONE.
- Latency: i_start accepted at edge N with i_dm_idle already high gives o_dm_run high in cycle N+2. i_dm_done at edge M gives the next o_dm_run at M+2 (if idle), or o_done at M+1 on the last chunk.
- Arithmetic: subtraction is in CNT_BIT width and cannot underflow, because a chunk is never larger than remaining. Chunk count = ceil(total/CHUNK).
- Reset mid-job returns to IDLE immediately. The scheduler does not reset the data mover.
- Spurious i_dm_done outside WAIT_DONE is ignored.

Test Plan:
- Single chunk: CHUNK=3840, total=3840, mover model idle → one o_dm_run with o_dm_num_cnt=3840. After done: o_chunk_idx=1, o_remaining=0, one o_done pulse.
- Multi-chunk: total=10000 → three runs with counts 3840, 3840, 2320. o_remaining goes 6160, 2320, 0. o_done is asserted exactly once.
- Zero length: total=0 → no o_dm_run, o_done 2 cycles after i_start, o_err=0.
- Abort: total=10000, i_abort raised during the first WAIT_DONE → first chunk completes, then no further run. o_aborted=1, o_remaining=6160, o_chunk_idx=1.
- Timeout: TO_BIT=4, mover never returns done → o_err=1 after 15 cycles in WAIT_DONE, o_done pulses, o_remaining=total. Next i_start clears o_err.
- Reset and back-pressure:
  - i_dm_idle held low for 20 cycles → o_dm_run is delayed accordingly.
  - Async reset asserted mid-WAIT_DONE → immediately o_idle=1, o_busy=0, o_dm_run=0. A new job then runs correctly.
